// File: rtl/rcc_pkg.sv
// Shared types and sizing helpers for the RCC SDRAM clock generator.
package rcc_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    CATCH = 3'd1,
    GATE  = 3'd2,
    SYNC  = 3'd3,
    OFF   = 3'd4
  } rcc_clkgen_state_t;

  // Width of the GATE/SYNC delay counter: enough to hold max(mux, sync) delay.
  function automatic int rcc_dly_w(input int mux_delay, input int sync_delay);
    int m;
    m = (mux_delay > sync_delay) ? mux_delay : sync_delay;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int RCC_DLY_W_DEFAULT = rcc_dly_w(2, 2);

endpackage

// File: rtl/rcc_div_cnt.sv
// Loadable up-counter 0..last with terminal-count flag; wraps to 0 on terminal.
// Latency: count updates one clk_i edge after en/load; tc is combinational.
// Backpressure: none, en simply freezes the count.
module rcc_div_cnt
  import rcc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         hw_rstn_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  assign tc = (cnt_q == last);

  always_ff @(posedge clk_i) begin
    if (!hw_rstn_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/rcc_sdram_clkgen.sv
// SDRAM clock generator: 50% duty register divider with glitch-free divisor switching.
// Latency: ack MUX_DELAY+SYNC_DELAY cycles after the falling toggle; first rise N cycles after ack.
// Backpressure: div_req_i is a level request held until div_ack_o; ignored while switching.
module rcc_sdram_clkgen
  import rcc_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int DIV_RST    = 2,
  parameter int MUX_DELAY  = 2,
  parameter int SYNC_DELAY = 2
) (
  input  logic             clk_i,
  input  logic             hw_rstn_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_req_i,
  output logic             div_ack_o,
  output logic             ready_o,
  output logic             clk_sdram_o,
  output logic             clk_rise_o,
  output logic [DIV_W-1:0] cur_div_o
);

  localparam int DLY_W = rcc_dly_w(MUX_DELAY, SYNC_DELAY);
  localparam logic [DLY_W-1:0] MUX_LAST  = DLY_W'(MUX_DELAY - 1);
  localparam logic [DLY_W-1:0] SYNC_LAST = DLY_W'(SYNC_DELAY - 1);

  rcc_clkgen_state_t state_q, state_d;
  logic             clk_q, clk_d;
  logic             rise_q;
  logic             ack_q, ack_d;
  logic             sw_pend_q, sw_pend_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;

  logic             div_en, div_tc;
  logic [DIV_W-1:0] div_last;
  logic             dly_en, dly_tc;
  logic [DLY_W-1:0] dly_last;

  assign div_en   = (state_q == RUN) || (state_q == CATCH);
  assign div_last = cur_div_q - DIV_W'(1);
  assign dly_en   = (state_q == GATE) || (state_q == SYNC);
  assign dly_last = (state_q == GATE) ? MUX_LAST : SYNC_LAST;

  rcc_div_cnt #(.W(DIV_W)) u_div_cnt (
    .clk_i     (clk_i),
    .hw_rstn_i (hw_rstn_i),
    .load      (!div_en),
    .load_val  ('0),
    .en        (div_en),
    .last      (div_last),
    .tc        (div_tc)
  );

  rcc_div_cnt #(.W(DLY_W)) u_dly_cnt (
    .clk_i     (clk_i),
    .hw_rstn_i (hw_rstn_i),
    .load      (!dly_en),
    .load_val  ('0),
    .en        (dly_en),
    .last      (dly_last),
    .tc        (dly_tc)
  );

  always_comb begin
    state_d   = state_q;
    clk_d     = clk_q;
    ack_d     = 1'b0;
    sw_pend_d = sw_pend_q;
    cur_div_d = cur_div_q;
    shadow_d  = shadow_q;
    case (state_q)
      RUN: begin
        if (div_tc) clk_d = ~clk_q;
        if (div_req_i) begin
          shadow_d  = div_i;
          sw_pend_d = 1'b1;
          // At a terminal count the current phase is complete: stop low without rising.
          if (div_tc) begin
            clk_d   = 1'b0;
            state_d = GATE;
          end else begin
            state_d = CATCH;
          end
        end
      end
      CATCH: begin
        if (div_tc) begin
          clk_d = ~clk_q;
          if (clk_q) state_d = GATE;
        end
      end
      OFF: begin
        clk_d = 1'b0;
        if (div_req_i) begin
          shadow_d  = div_i;
          sw_pend_d = 1'b1;
          state_d   = GATE;
        end
      end
      GATE: begin
        clk_d = 1'b0;
        if (dly_tc) begin
          cur_div_d = shadow_q;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        clk_d = 1'b0;
        if (dly_tc) begin
          state_d   = (cur_div_q != '0) ? RUN : OFF;
          ack_d     = sw_pend_q;
          sw_pend_d = 1'b0;
        end
      end
      default: begin
        clk_d   = 1'b0;
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!hw_rstn_i) begin
      state_q   <= SYNC;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      ack_q     <= 1'b0;
      sw_pend_q <= 1'b0;
      cur_div_q <= DIV_W'(DIV_RST);
      shadow_q  <= DIV_W'(DIV_RST);
    end else begin
      state_q   <= state_d;
      clk_q     <= clk_d;
      rise_q    <= clk_d & ~clk_q;
      ack_q     <= ack_d;
      sw_pend_q <= sw_pend_d;
      cur_div_q <= cur_div_d;
      shadow_q  <= shadow_d;
    end
  end

  assign clk_sdram_o = clk_q;
  assign clk_rise_o  = rise_q;
  assign div_ack_o   = ack_q;
  assign cur_div_o   = cur_div_q;
  assign ready_o     = (state_q == RUN) || (state_q == OFF);

endmodule

// File: tb/tb_rcc_sdram_clkgen.sv
// Directed bench for rcc_sdram_clkgen: reset, divisor switches, OFF mode, reset mid-switch.
module tb_rcc_sdram_clkgen;

  logic       clk_i = 1'b0;
  logic       hw_rstn_i;
  logic [7:0] div_i;
  logic       div_req_i;
  logic       div_ack_o;
  logic       ready_o;
  logic       clk_sdram_o;
  logic       clk_rise_o;
  logic [7:0] cur_div_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_n    = 2;
  int hi_len   = 0;
  int rise_cnt = 0;
  int ack_cnt  = 0;
  logic prev_sd = 1'b0;
  bit   chk_en  = 1'b0;

  always #5 clk_i = ~clk_i;

  rcc_sdram_clkgen #(
    .DIV_W(8), .DIV_RST(2), .MUX_DELAY(2), .SYNC_DELAY(2)
  ) dut (
    .clk_i       (clk_i),
    .hw_rstn_i   (hw_rstn_i),
    .div_i       (div_i),
    .div_req_i   (div_req_i),
    .div_ack_o   (div_ack_o),
    .ready_o     (ready_o),
    .clk_sdram_o (clk_sdram_o),
    .clk_rise_o  (clk_rise_o),
    .cur_div_o   (cur_div_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // which: 0 = ack pulse, 1 = rise pulse, 2 = sdram clock low
  task automatic wait_for(input string tag, input int which, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (which)
        0:       hit = div_ack_o;
        1:       hit = clk_rise_o;
        default: hit = !clk_sdram_o;
      endcase
    end
    check(tag, hit, 1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_sdram"}, clk_sdram_o, 0);
    check({pfx, "_rise"},  clk_rise_o,  0);
    check({pfx, "_ack"},   div_ack_o,   0);
    check({pfx, "_ready"}, ready_o,     0);
    check({pfx, "_div"},   cur_div_o,   2);
  endtask

  initial begin
    int n;
    int k;
    int acks_before;
    hw_rstn_i = 1'b0;
    div_req_i = 1'b0;
    div_i     = 8'd0;

    fork
      forever begin
        @(negedge clk_i);
        if (chk_en) begin
          check("rise_align", clk_rise_o, clk_sdram_o & ~prev_sd);
          if (clk_sdram_o) begin
            hi_len++;
          end else if (hi_len != 0) begin
            check("high_width", hi_len, exp_n);
            hi_len = 0;
          end
          if (clk_rise_o) rise_cnt++;
          if (div_ack_o) ack_cnt++;
        end
        prev_sd = clk_sdram_o;
      end
    join_none

    // Reset and start-up with DIV_RST=2
    repeat (3) tick();
    chk_en = 1'b1;
    check_reset("rst");
    hw_rstn_i = 1'b1;
    tick();
    check("ready_in_sync", ready_o, 0);
    tick();
    check("ready_run", ready_o, 1);
    check("no_ack_after_reset", div_ack_o, 0);
    wait_for("first_rise", 1, 10, n);
    check("first_rise_lat", n, 2);
    check("cur_div_rst", cur_div_o, 2);
    wait_for("rise2", 1, 10, n);
    check("period_n2", n, 4);

    // Switch 2 -> 5 requested in the high phase
    div_i = 8'd5; div_req_i = 1'b1;
    wait_for("fall_2to5", 2, 10, n);
    check("high_done_2to5", n, 2);
    check("ready_switching", ready_o, 0);
    wait_for("ack_2to5", 0, 20, n);
    check("ack_lat_2to5", n, 4);
    check("cur_div_5", cur_div_o, 5);
    div_req_i = 1'b0; exp_n = 5;
    wait_for("rise_n5", 1, 20, n);
    check("rise_after_ack_5", n, 5);
    wait_for("rise_n5b", 1, 30, n);
    check("period_n5", n, 10);

    // Switch to 0 (OFF), then 3 from OFF
    div_i = 8'd0; div_req_i = 1'b1;
    wait_for("ack_to0", 0, 30, n);
    check("ack_lat_to0", n, 9);
    check("cur_div_0", cur_div_o, 0);
    check("ready_off", ready_o, 1);
    div_req_i = 1'b0; exp_n = 0;
    k = rise_cnt;
    repeat (50) tick();
    check("off_no_rise", rise_cnt - k, 0);
    check("off_low", clk_sdram_o, 0);
    div_i = 8'd3; div_req_i = 1'b1;
    wait_for("ack_off_to3", 0, 20, n);
    check("ack_lat_off_to3", n, 5);  // first edge accepts, ack 4 edges later
    check("cur_div_3", cur_div_o, 3);
    div_req_i = 1'b0; exp_n = 3;
    wait_for("rise_n3", 1, 20, n);
    check("rise_after_ack_3", n, 3);
    wait_for("rise_n3b", 1, 20, n);
    check("period_n3", n, 6);

    // Reset asserted during GATE aborts the switch
    acks_before = ack_cnt;
    div_i = 8'd4; div_req_i = 1'b1;
    wait_for("fall_3to4", 2, 20, n);
    check("high_done_3to4", n, 3);
    tick();
    check("ready_gate", ready_o, 0);
    hw_rstn_i = 1'b0; div_req_i = 1'b0; exp_n = 2;
    tick();
    check_reset("midrst");
    tick();
    hw_rstn_i = 1'b1;
    tick();
    tick();
    check("ready_after_midrst", ready_o, 1);
    check("no_ack_midrst", div_ack_o, 0);
    wait_for("rise_midrst", 1, 10, n);
    check("rise_lat_midrst", n, 2);
    wait_for("rise_midrst2", 1, 10, n);
    check("period_midrst", n, 4);
    check("no_ack_count_midrst", ack_cnt - acks_before, 0);

    // Request held past the ack with div=1 starts a second switch
    div_i = 8'd1; div_req_i = 1'b1;
    wait_for("ack_to1", 0, 30, n);
    check("ack_lat_to1", n, 6);
    check("cur_div_1", cur_div_o, 1);
    exp_n = 1;
    wait_for("ack_held", 0, 20, n);
    check("ack_lat_held", n, 5);
    div_req_i = 1'b0;
    wait_for("rise_n1", 1, 10, n);
    check("rise_after_ack_1", n, 1);
    wait_for("rise_n1b", 1, 10, n);
    check("period_n1", n, 2);

    // 1 -> 2, then same-value 2 -> 2
    div_i = 8'd2; div_req_i = 1'b1;
    wait_for("ack_1to2", 0, 20, n);
    check("ack_lat_1to2", n, 5);
    div_req_i = 1'b0; exp_n = 2;
    wait_for("rise_1to2", 1, 10, n);
    check("rise_after_ack_2", n, 2);
    div_req_i = 1'b1;
    wait_for("ack_2to2", 0, 20, n);
    check("ack_lat_2to2", n, 6);
    check("cur_div_2to2", cur_div_o, 2);
    div_req_i = 1'b0;
    wait_for("rise_2to2", 1, 10, n);
    check("rise_after_ack_2to2", n, 2);
    wait_for("rise_2to2b", 1, 10, n);
    check("period_2to2", n, 4);
    tick();
    check("ack_total", ack_cnt, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
